fir_serial_mac: RTL

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_coef_regfile.sv | 36 +++
 rtl/fir_serial_mac.sv | 107 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths and FSM encoding for the serial-MAC FIR datapath.
// Widths sized so the accumulator cannot overflow across all taps.
package fir_pkg;

    localparam int DATA_W = 12;
    localparam int COEF_W = 12;
    localparam int TAPS   = 8;
    localparam int SEL_W  = 3;
    localparam int ACC_W  = DATA_W + COEF_W + SEL_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_t;

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient storage: one write port, one combinational read port.
// Flops rather than RAM because the read must be same-cycle and reset-clearable.
module fir_coef_regfile
    import fir_pkg::*;
#(
    parameter int DEPTH = TAPS,
    parameter int WIDTH = COEF_W,
    parameter int AW    = SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic signed [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]           i_rd_addr,
    output logic signed [WIDTH-1:0] o_rd_data
);

    logic signed [WIDTH-1:0] r_coef [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_coef
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_coef[gi] <= '0;
                end else if (i_wr_en && (i_wr_addr == AW'(gi))) begin
                    r_coef[gi] <= i_wr_data;
                end
            end
        end
    endgenerate

    assign o_rd_data = r_coef[i_rd_addr];

endmodule

// File: rtl/fir_serial_mac.sv
// Serial multiply-accumulate FIR: walks an external 8:1 tap mux, one tap per cycle,
// and pulses result_valid with the full-precision dot product.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int COEF_W_P = COEF_W,
    parameter int TAPS_P   = TAPS,
    parameter int ACC_W_P  = ACC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic [SEL_W-1:0]           select_lines,
    input  logic signed [DATA_W_P-1:0] tap_data,
    input  logic                       coef_wr_en,
    input  logic [SEL_W-1:0]           coef_wr_addr,
    input  logic signed [COEF_W_P-1:0] coef_wr_data,
    output logic signed [ACC_W_P-1:0]  result,
    output logic                       result_valid
);

    localparam int PROD_W = DATA_W_P + COEF_W_P;

    fir_state_t               r_state;
    logic                     r_busy;
    logic [SEL_W-1:0]         r_sel;
    logic signed [ACC_W_P-1:0] r_acc;
    logic signed [ACC_W_P-1:0] r_result;
    logic                     r_result_valid;

    logic                      w_coef_we;
    logic signed [COEF_W_P-1:0] w_coef;
    logic signed [PROD_W-1:0]   w_product;
    logic signed [ACC_W_P-1:0]  w_product_ext;
    logic signed [ACC_W_P-1:0]  w_sum;
    logic                       w_last_tap;

    // Coefficients are frozen for the duration of a computation.
    assign w_coef_we = coef_wr_en & ~r_busy;

    fir_coef_regfile #(
        .DEPTH (TAPS_P),
        .WIDTH (COEF_W_P),
        .AW    (SEL_W)
    ) u_coef_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_coef_we),
        .i_wr_addr (coef_wr_addr),
        .i_wr_data (coef_wr_data),
        .i_rd_addr (r_sel),
        .o_rd_data (w_coef)
    );

    assign w_product     = tap_data * w_coef;
    assign w_product_ext = {{(ACC_W_P - PROD_W){w_product[PROD_W-1]}}, w_product};
    assign w_sum         = r_acc + w_product_ext;
    assign w_last_tap    = (r_sel == SEL_W'(TAPS_P - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_sel          <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sel <= '0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_acc   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_sum;
                    if (w_last_tap) begin
                        r_result       <= w_sum;
                        r_result_valid <= 1'b1;
                        r_sel          <= '0;
                        r_state        <= ST_IDLE;
                        r_busy         <= 1'b0;
                    end else begin
                        r_sel <= r_sel + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign select_lines = r_sel;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
